mesh_pattern_decoder: RTL and testbench
=======================================

# mesh_pattern_decoder

Consumer side of the 4x4 sensor-mesh LED-pattern stream. The mesh block buffers one 4-bit pattern per node in a 16-deep FIFO and presents it on its registered `led` output one cycle after a read strobe. This block drives that read strobe and pulls one full frame of 16 patterns in slot order, node 0 through node 15. It then decodes the frame into a 16-bit active-node map, an active count and an error flag, for downstream logging or display logic.

## Interface
- `NODES`, 16: slots per frame; fixed at 16 for the 4x4 mesh.
- `CODE_W`, 4: pattern width; `$clog2(NODES)`.
- `clk`  input  1  single clock; all logic on the rising edge.
- `reset`  input  1  synchronous, active-low; sampled on the rising edge of `clk`.
- `start`  input  1  one-cycle request to decode a frame; honoured only in IDLE.
- `avail`  input  1  upstream FIFO non-empty (upstream Count != 0).
- `led_in`  input  CODE_W  upstream registered pattern output.
- `rd`  output  1  read strobe to upstream; Mealy: `rd = (state==REQ) && avail`.
- `node_map`  output  NODES  bit k = node k reported active in the last completed frame.
- `active_cnt`  output  5  popcount of `node_map` (0..16).
- `frame_done`  output  1  one-cycle pulse when `node_map`/`active_cnt` update.
- `code_err`  output  1  sticky per frame; a nonzero code did not match its slot.
- `busy`  output  1  high in REQ and CAPT.

## Operation
- The FSM has three states.
  - IDLE: when `start`=1, clear `slot`, the shadow map and the frame error, then go to REQ.
  - REQ: if `avail`=1, `rd` is high this cycle and the FSM goes to CAPT. Otherwise it stays in REQ with `rd`=0, which is a stall with no timeout.
  - CAPT: sample `led_in` into slot `slot`. If `slot`==15, commit the frame and go to IDLE. Otherwise increment `slot` and go to REQ.
- Decode rule for slot k with code c:
  - c==k and k!=0: set shadow bit k.
  - c==0: the bit stays 0. An inactive node emits 0000.
  - c!=0 and c!=k: the bit stays 0 and the frame error is set.
- Slot 0 is never reportable. Node 0 emits 0000 whether active or not, so `node_map[0]` is always 0.
- `slot` is 4 bits and is compared against 15, never wrapped. The frame ends after exactly 16 captures.
- Commit happens at the slot-15 capture edge:
  - `node_map` takes the shadow map with slot 15's bit merged in.
  - `active_cnt` takes the popcount of that same value.
  - `code_err` takes the accumulated error, including slot 15.
  - `frame_done` is set for 1 cycle.
- Outputs from frame N stay stable until frame N+1 commits. `code_err` is replaced at each commit, not ORed across frames.
- `start` while `busy` is ignored; no queuing.
- Reset (`reset`=0), at any point including mid-frame:
  - state goes to IDLE and `slot` to 0; the shadow is cleared.
  - `node_map`=0, `active_cnt`=0, `frame_done`=0, `code_err`=0, `busy`=0, and `rd`=0 follows from IDLE.
  - An upstream read already issued is lost. The upstream FIFO is not rewound.

## Timing
- `start` is sampled at edge E; REQ holds from E.
- With `avail` constantly 1, the strobe for slot k is high in the cycle ending at edge E+2k+1. Upstream updates `led` at that edge, and this block captures it at edge E+2k+2.
- Slot 15 is captured at E+32. `frame_done`, `node_map`, `active_cnt` and `code_err` are valid in the cycle after E+32. Minimum frame latency is 32 cycles.
- Each cycle `avail`=0 in REQ adds exactly 1 cycle. `rd` is never high outside REQ and never two cycles in a row.
- `led_in` is sampled only in CAPT; its value in other cycles is don't-care.
- `frame_done` is high for exactly 1 cycle per frame. The earliest next `start` is accepted in that same cycle, because the FSM is already in IDLE.

## Test plan
- Reset is low 3 cycles, then high: all outputs are 0 and `rd` stays 0 with `avail`=1 and no `start`.
- Frame codes k for slot k (0..15), `avail`=1: `frame_done` in the cycle after E+32; `node_map`=16'hFFFE, `active_cnt`=15, `code_err`=0, and exactly 16 `rd` pulses.
- All codes 0: `node_map`=0, `active_cnt`=0, `code_err`=0.
- Codes k except slot 5 gives 4'h7 and slot 9 gives 4'h0: `node_map`=16'hFDDE, `active_cnt`=13, `code_err`=1. A following all-match frame returns `code_err`=0.
- Stall and busy handling:
  - Setup: `avail`=0 for 4 cycles at slot 3 and 2 cycles at slot 12, with `start` re-pulsed while busy.
  - Required: `frame_done` in the cycle after E+38, correct map, and the extra `start` ignored.
- Reset low at slot 8, mid-frame:
  - Required: outputs return to 0 on the next edge and no `frame_done` follows.
  - Then a new `start` with an all-match frame gives `node_map`=16'hFFFE.

Source files
------------

// File: rtl/mesh_pattern_decoder.sv
// Pulls one 16-slot LED-pattern frame from the mesh FIFO and decodes it into
// an active-node map, an active count and a per-frame code error flag.
module mesh_pattern_decoder #(
  parameter int NODES  = 16,
  parameter int CODE_W = $clog2(NODES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       avail,
  input  logic [CODE_W-1:0]          led_in,
  output logic                       rd,
  output logic [NODES-1:0]           node_map,
  output logic [$clog2(NODES+1)-1:0] active_cnt,
  output logic                       frame_done,
  output logic                       code_err,
  output logic                       busy
);

  localparam int CNT_W = $clog2(NODES + 1);

  typedef enum logic [1:0] {IDLE, REQ, CAPT} state_e;

  state_e             state_q,      state_d;
  logic [CODE_W-1:0]  slot_q,       slot_d;
  logic [NODES-1:0]   shadow_q,     shadow_d;
  logic               err_q,        err_d;
  logic [NODES-1:0]   node_map_q,   node_map_d;
  logic [CNT_W-1:0]   active_cnt_q, active_cnt_d;
  logic               code_err_q,   code_err_d;
  logic               frame_done_q, frame_done_d;

  logic               hit;
  logic               bad;
  logic [NODES-1:0]   merged;

  function automatic logic [CNT_W-1:0] popcount(input logic [NODES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NODES; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  // Slot 0 can never report active: node 0 emits 0000 whether active or not.
  assign hit    = (led_in == slot_q) && (slot_q != '0);
  assign bad    = (led_in != '0) && (led_in != slot_q);
  assign merged = shadow_q | (hit ? (NODES'(1) << slot_q) : '0);

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d      = state_q;
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    err_d        = err_q;
    node_map_d   = node_map_q;
    active_cnt_d = active_cnt_q;
    code_err_d   = code_err_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          slot_d   = '0;
          shadow_d = '0;
          err_d    = 1'b0;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (avail) state_d = CAPT;
      end
      CAPT: begin
        shadow_d = merged;
        err_d    = err_q | bad;
        if (slot_q == CODE_W'(NODES - 1)) begin
          // Slot 15 is merged straight into the committed outputs.
          node_map_d   = merged;
          active_cnt_d = popcount(merged);
          code_err_d   = err_q | bad;
          frame_done_d = 1'b1;
          state_d      = IDLE;
        end else begin
          slot_d  = slot_q + 1'b1;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q      <= IDLE;
      slot_q       <= '0;
      shadow_q     <= '0;
      err_q        <= 1'b0;
      node_map_q   <= '0;
      active_cnt_q <= '0;
      code_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      err_q        <= err_d;
      node_map_q   <= node_map_d;
      active_cnt_q <= active_cnt_d;
      code_err_q   <= code_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rd         = (state_q == REQ) && avail;
  assign busy       = (state_q != IDLE);
  assign node_map   = node_map_q;
  assign active_cnt = active_cnt_q;
  assign code_err   = code_err_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_mesh_pattern_decoder.sv
// Bench for mesh_pattern_decoder: models the upstream FIFO, predicts each frame
// when start is accepted and compares on every frame_done.
module tb_mesh_pattern_decoder;

  logic        clk = 1'b0;
  logic        reset, start, avail;
  logic [3:0]  led_in;
  logic        rd;
  logic [15:0] node_map;
  logic [4:0]  active_cnt;
  logic        frame_done, code_err, busy;

  always #5 clk = ~clk;

  mesh_pattern_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .avail      (avail),
    .led_in     (led_in),
    .rd         (rd),
    .node_map   (node_map),
    .active_cnt (active_cnt),
    .frame_done (frame_done),
    .code_err   (code_err),
    .busy       (busy)
  );

  typedef struct {
    logic [15:0] map;
    logic [4:0]  cnt;
    logic        err;
    int          done_cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] codes[16];
  int         stall_at[16];
  int         rd_idx = 0, stall_left = 0, cyc = 0, rd_cnt = 0, done_cnt = 0;
  bit         frame_active = 0, prev_rd = 0, start_pend = 0, reset_v = 0, last_rd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict();
    exp_t e;
    int   extra;
    e.map = '0;
    e.err = 1'b0;
    e.cnt = '0;
    extra = 0;
    for (int k = 0; k < 16; k++) begin
      if (codes[k] == 4'(k) && k != 0) e.map[k] = 1'b1;
      else if (codes[k] != 4'h0 && codes[k] != 4'(k)) e.err = 1'b1;
      extra += stall_at[k];
    end
    for (int k = 0; k < 16; k++) e.cnt += 5'(e.map[k]);
    e.done_cyc = cyc + 32 + extra;
    return e;
  endfunction

  // One clock: drive at negedge, observe 1 unit later, act as upstream after posedge.
  task automatic tick();
    bit   rd_now, start_now;
    exp_t e;
    @(negedge clk);
    avail = (stall_left > 0) ? 1'b0 : 1'b1;
    if (stall_left > 0) stall_left--;
    start      = start_pend;
    start_now  = start_pend;
    start_pend = 0;
    reset      = reset_v;
    #1;
    rd_now  = rd;
    last_rd = rd_now;
    if (rd_now) begin
      rd_cnt++;
      check("rd_back_to_back", 32'(prev_rd), 0);
    end
    if (frame_done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("spurious_done", 32'(frame_done), 0);
      end else begin
        e = sb.pop_front();
        check("node_map",   node_map,   e.map);
        check("active_cnt", active_cnt, e.cnt);
        check("code_err",   code_err,   e.err);
        check("done_cycle", cyc,        e.done_cyc);
        check("rd_pulses",  rd_cnt,     16);
        frame_active = 0;
      end
    end
    if (reset_v) check("busy", 32'(busy), 32'(frame_active));
    prev_rd = rd_now;
    @(posedge clk);
    cyc++;
    if (!reset_v) begin
      sb.delete();
      frame_active = 0;
      stall_left   = 0;
    end else if (start_now && !frame_active) begin
      sb.push_back(predict());
      frame_active = 1;
      rd_idx       = 0;
      rd_cnt       = 0;
    end
    #1;
    if (rd_now && reset_v && rd_idx < 16) begin
      led_in = codes[rd_idx];
      rd_idx++;
      if (rd_idx < 16 && stall_at[rd_idx] > 0) stall_left = stall_at[rd_idx] + 1;
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    check("done_timeout", sb.size(), 0);
    sb.delete();
    frame_active = 0;
  endtask

  task automatic set_match();
    for (int k = 0; k < 16; k++) codes[k] = 4'(k);
  endtask

  task automatic start_frame();
    start_pend = 1;
    tick();
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    avail  = 1'b1;
    led_in = 4'h0;
    foreach (stall_at[k]) stall_at[k] = 0;
    set_match();

    reset_v = 0;
    repeat (3) tick();
    reset_v = 1;
    tick();
    check("rst_node_map",   node_map,   0);
    check("rst_active_cnt", active_cnt, 0);
    check("rst_code_err",   code_err,   0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy",       busy,       0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("idle_rd", 32'(last_rd), 0);
    end

    // All slots match their own index.
    set_match();
    start_frame();
    wait_done(60);
    check("match_map", node_map,   16'hFFFE);
    check("match_cnt", active_cnt, 15);
    check("match_err", code_err,   0);

    // Every node inactive.
    foreach (codes[k]) codes[k] = 4'h0;
    start_frame();
    wait_done(60);
    check("zero_map", node_map,   0);
    check("zero_cnt", active_cnt, 0);
    check("zero_err", code_err,   0);

    // Slot 5 mismatched, slot 9 inactive.
    set_match();
    codes[5] = 4'h7;
    codes[9] = 4'h0;
    start_frame();
    wait_done(60);
    check("bad_map", node_map,   16'hFDDE);
    check("bad_cnt", active_cnt, 13);
    check("bad_err", code_err,   1);

    set_match();
    start_frame();
    wait_done(60);
    check("clean_err", code_err, 0);

    // Upstream stalls at slots 3 and 12, plus a start while busy.
    stall_at[3]  = 4;
    stall_at[12] = 2;
    start_frame();
    for (int i = 0; i < 40 && rd_idx < 6; i++) tick();
    start_pend = 1;
    wait_done(80);
    check("stall_map", node_map,   16'hFFFE);
    check("stall_cnt", active_cnt, 15);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("ignored_start_busy", 32'(busy), 0);
    end
    foreach (stall_at[k]) stall_at[k] = 0;

    // Reset mid-frame around slot 8.
    foreach (codes[k]) codes[k] = 4'($urandom_range(0, 15));
    start_frame();
    for (int i = 0; i < 40 && rd_idx < 8; i++) tick();
    reset_v = 0;
    tick();
    reset_v = 1;
    check("mid_rst_node_map",   node_map,   0);
    check("mid_rst_active_cnt", active_cnt, 0);
    check("mid_rst_code_err",   code_err,   0);
    check("mid_rst_busy",       busy,       0);
    check("mid_rst_rd",         rd,         0);
    done_cnt = 0;
    repeat (40) tick();
    check("no_done_after_reset", done_cnt, 0);

    set_match();
    start_frame();
    wait_done(60);
    check("post_rst_map", node_map, 16'hFFFE);
    check("post_rst_cnt", active_cnt, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
